// File: rtl/uart_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_if
//
// Groups the transmit request/data handshake and the serial-side outputs of
// the UART transmitter, so that the producer and the transmitter can be
// wired through a single port.
//
// Signals:
//   tx_start     request pulse from the producer
//   tx_data_in   byte to send (captured when the request is accepted)
//   tx_data_out  serial line (idle high)
//   tx_busy      frame in progress
//   tx_done      one-cycle pulse after the stop bit
//
// Modports:
//   master  producer side (drives request and data, observes status)
//   slave   transmitter side (takes request and data, drives line and status)
// -----------------------------------------------------------------------------
interface uart_transmitter_if;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_data_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data_in,
        input  tx_data_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data_in,
        output tx_data_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises one byte per request as a UART frame: start bit (0), eight data
// bits LSB first, an optional parity bit, and a stop bit (1). Every bit is
// held for CLKS_PER_BIT clocks. All outputs come straight from flops.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 1)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   uart_transmitter_if.slave (tx_start, tx_data_in in;
//         tx_data_out, tx_busy, tx_done out)
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit is sent between the data
//                      bits and the stop bit (11-bit frame); otherwise the
//                      frame is 10 bits and PARITY_ODD has no effect.
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    uart_transmitter_if.slave  bus
);

    localparam int BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [BaudW-1:0] baud_q;
    logic             line_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`else
    // Without a parity bit the polarity setting has nothing to act on.
    logic             parity_odd_unused;
    assign parity_odd_unused = PARITY_ODD;
`endif

    // The current bit has been on the line for its full CLKS_PER_BIT cycles.
    assign bit_end = (baud_q == BaudLast);

    // Frame sequencer. The line, busy and done flops are loaded with the
    // values belonging to the state being entered, so they change on the
    // same edge as the state and no output depends combinationally on
    // an input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.tx_start) begin
                        shift_q   <= bus.tx_data_in;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^bus.tx_data_in) ^ PARITY_ODD;
`endif
                        bit_idx_q <= '0;
                        baud_q    <= '0;
                        line_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        line_q  <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            line_q  <= parity_q;
                            state_q <= PARITY;
`else
                            line_q  <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            // shift_q[1] becomes shift_q[0] on this edge.
                            line_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        line_q  <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        line_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data_out = line_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Drives three transmitter instances (1, 4 and 3 clocks per bit; the 4-clock
// one uses odd parity) from one shared stimulus stream and checks every
// output of every instance on every cycle against a frame-position model:
// after a request is accepted, cycle p of the frame carries frame bit
// (p-1)/CLKS_PER_BIT, and the cycle after the last bit carries the done pulse.
// Directed sequences cover the worked examples, back-to-back frames, ignored
// requests and reset during a frame; a random phase follows.
// Honours UART_TX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int NDut = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;

    logic lineOut [NDut];
    logic busyOut [NDut];
    logic doneOut [NDut];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state, one entry per instance.
    bit         mActive [NDut];
    int         mPos    [NDut];
    logic [7:0] mByte   [NDut];
    bit         modelValid = 1'b0;

    logic       sRst;
    logic       sStart;
    logic [7:0] sData;

    uart_transmitter_if bus0 ();
    uart_transmitter_if bus1 ();
    uart_transmitter_if bus2 ();

    assign bus0.tx_start = txStart;
    assign bus0.tx_data_in = txData;
    assign bus1.tx_start = txStart;
    assign bus1.tx_data_in = txData;
    assign bus2.tx_start = txStart;
    assign bus2.tx_data_in = txData;

    assign lineOut[0] = bus0.tx_data_out;
    assign busyOut[0] = bus0.tx_busy;
    assign doneOut[0] = bus0.tx_done;
    assign lineOut[1] = bus1.tx_data_out;
    assign busyOut[1] = bus1.tx_busy;
    assign doneOut[1] = bus1.tx_done;
    assign lineOut[2] = bus2.tx_data_out;
    assign busyOut[2] = bus2.tx_busy;
    assign doneOut[2] = bus2.tx_done;

    uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    uart_transmitter #(.CLKS_PER_BIT(3), .PARITY_ODD(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Instance configuration, kept in step with the instantiations above.
    function automatic int cpbOf(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int oddOf(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Whole frame as a bit vector, index 0 = first bit on the line.
    // Positions past the stop bit are padded with 1.
    function automatic logic [10:0] frameWord(input logic [7:0] b, input int odd);
        logic [10:0] w;
        int ones;
        w = '1;
        ones = 0;
        w[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i + 1] = b[i];
            ones += int'(b[i]);
        end
`ifdef UART_TX_PARITY_EN
        w[9] = (((ones + odd) % 2) == 1);
`else
        ones += odd;
`endif
        return w;
    endfunction

    function automatic logic frameBit(input logic [7:0] b, input int odd, input int idx);
        logic [10:0] w;
        w = frameWord(b, odd);
        return w[idx];
    endfunction

    // Drives inputs for the edge ending the current cycle; returns just after
    // the falling edge, so outputs read afterwards belong to this cycle.
    task automatic applyStimulus(input logic start, input logic [7:0] data, input logic rstVal);
        @(negedge clk);
        txStart = start;
        txData  = data;
        rst     = rstVal;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            idle = 1'b1;
            for (int i = 0; i < NDut; i++)
                if (busyOut[i] !== 1'b0 || doneOut[i] !== 1'b0) idle = 1'b0;
        end
        if (!idle) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    // Reference model and per-cycle comparison. Inputs are sampled at the
    // rising edge; the model advances and the outputs are checked 1 time unit
    // later, once the design has settled.
    always @(posedge clk) begin
        int last;
        int cpb;
        logic expLine, expBusy, expDone;
        sRst   = rst;
        sStart = txStart;
        sData  = txData;
        #1;
        cyc++;
        for (int i = 0; i < NDut; i++) begin
            cpb  = cpbOf(i);
            last = cpb * F + 1;
            if (sRst) begin
                mActive[i] = 1'b0;
                mPos[i]    = 0;
            end else if (modelValid) begin
                if ((!mActive[i] || mPos[i] == last) && sStart) begin
                    mActive[i] = 1'b1;
                    mPos[i]    = 1;
                    mByte[i]   = sData;
                end else if (mActive[i]) begin
                    mPos[i]++;
                    if (mPos[i] > last) mActive[i] = 1'b0;
                end
            end
        end
        if (sRst) modelValid = 1'b1;
        if (modelValid) begin
            for (int i = 0; i < NDut; i++) begin
                cpb  = cpbOf(i);
                last = cpb * F + 1;
                if (mActive[i] && mPos[i] < last) begin
                    expLine = frameBit(mByte[i], oddOf(i), (mPos[i] - 1) / cpb);
                    expBusy = 1'b1;
                    expDone = 1'b0;
                end else if (mActive[i]) begin
                    expLine = 1'b1;
                    expBusy = 1'b0;
                    expDone = 1'b1;
                end else begin
                    expLine = 1'b1;
                    expBusy = 1'b0;
                    expDone = 1'b0;
                end
                checkOutput($sformatf("model.line.dut%0d", i), 32'(lineOut[i]), 32'(expLine));
                checkOutput($sformatf("model.busy.dut%0d", i), 32'(busyOut[i]), 32'(expBusy));
                checkOutput($sformatf("model.done.dut%0d", i), 32'(doneOut[i]), 32'(expDone));
            end
        end
    end

    initial begin
        logic [10:0] litA5;
        logic [10:0] litOdd07;
        logic [10:0] litEven07;
`ifdef UART_TX_PARITY_EN
        litA5     = 11'h54A;
        litOdd07  = 11'h40E;
        litEven07 = 11'h60E;
`else
        litA5     = 11'h74A;
        litOdd07  = 11'h60E;
        litEven07 = 11'h60E;
`endif
        $display("[TB] start, frame length %0d bits", F);

        // Hand-derived frames that pin the model's bit ordering and parity.
        checkOutput("pin.frameA5even", 32'(frameWord(8'hA5, 0)), 32'(litA5));
        checkOutput("pin.frame07odd",  32'(frameWord(8'h07, 1)), 32'(litOdd07));
        checkOutput("pin.frame07even", 32'(frameWord(8'h07, 0)), 32'(litEven07));

        // Reset and idle state.
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset.line", 32'(lineOut[0]), 32'd1);
        checkOutput("reset.busy", 32'(busyOut[0]), 32'd0);
        checkOutput("reset.done", 32'(doneOut[0]), 32'd0);

        // 0xA5 on the 1-clock instance, then 0x55 requested in the done cycle.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int j = 1; j <= F; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("a5.line.c%0d", j), 32'(lineOut[0]), 32'(litA5[j - 1]));
            checkOutput($sformatf("a5.busy.c%0d", j), 32'(busyOut[0]), 32'd1);
        end
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("a5.done", 32'(doneOut[0]), 32'd1);
        checkOutput("a5.doneBusy", 32'(busyOut[0]), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("b2b.startBit", 32'(lineOut[0]), 32'd0);
        checkOutput("b2b.busy", 32'(busyOut[0]), 32'd1);
        // Request with 0x3C in the middle of the 0x55 data bits is dropped.
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ignored.busy", 32'(busyOut[0]), 32'd1);
        waitIdle();

        // Bit stretching on the 4-clock instance with 0x80.
        applyStimulus(1'b1, 8'h80, 1'b0);
        for (int j = 1; j <= 4 * F + 1; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (j <= 4)
                checkOutput($sformatf("s80.start.c%0d", j), 32'(lineOut[1]), 32'd0);
            if (j >= 29 && j <= 32)
                checkOutput($sformatf("s80.bit6.c%0d", j), 32'(lineOut[1]), 32'd0);
            if (j >= 33 && j <= 36)
                checkOutput($sformatf("s80.bit7.c%0d", j), 32'(lineOut[1]), 32'd1);
            if (j == 4 * F)
                checkOutput("s80.noEarlyDone", 32'(doneOut[1]), 32'd0);
            if (j == 4 * F + 1)
                checkOutput("s80.done", 32'(doneOut[1]), 32'd1);
        end
        waitIdle();

        // Reset pulse during the data bits, then a clean 0xA5 frame.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int j = 1; j <= 3; j++) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NDut; i++) begin
            checkOutput($sformatf("midReset.line.dut%0d", i), 32'(lineOut[i]), 32'd1);
            checkOutput($sformatf("midReset.busy.dut%0d", i), 32'(busyOut[i]), 32'd0);
            checkOutput($sformatf("midReset.done.dut%0d", i), 32'(doneOut[i]), 32'd0);
        end
        applyStimulus(1'b1, 8'hA5, 1'b0);
        waitIdle();

        // Random requests, data and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 99) == 0));
        end
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
